// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state encodings and default tick division for the stopwatch control block
package stopwatch_pkg;
  typedef enum logic [1:0] {
    CLEARED = 2'b00,
    RUN     = 2'b01,
    STOPPED = 2'b10,
    LAP     = 2'b11
  } state_e;
  localparam int TICK_DIV_DEF = 262144;
  localparam int PRE_W_DEF = 18;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detect producing a one-cycle button event
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic evt_o
);
  logic s1_q, s2_q, s3_q, fill_q, armed_q;
  // armed only after a genuine low sample, so a button held through reset release never fires
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill_q  <= 1'b1;
      armed_q <= armed_q | (fill_q & ~s1_q);
    end
  end
  assign evt_o = armed_q & s2_q & ~s3_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/stop/lap/clear FSM with synchronous tick prescaler
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PRE_W    = PRE_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       strtstop_i,
  input  logic       lap_i,
  input  logic       clr_i,
  output logic       cnt_en_o,
  output logic       cnt_clr_o,
  output logic       disp_hold_o,
  output logic       running_o,
  output logic [1:0] state_o
);
  logic ss_evt, lap_evt, clr_evt;
  logic active, tick;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic cnt_en_q, cnt_clr_q, hold_q, running_q;
  state_e state_q, state_d;
  btn_sync_edge u_ss  (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(strtstop_i), .evt_o(ss_evt));
  btn_sync_edge u_lap (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(lap_i),      .evt_o(lap_evt));
  btn_sync_edge u_clr (.clk_i(clk_i), .rst_n_i(rst_n_i), .btn_i(clr_i),      .evt_o(clr_evt));
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEARED: state_d = ss_evt ? RUN : CLEARED;
      RUN:     state_d = ss_evt ? STOPPED : lap_evt ? LAP : RUN;
      LAP:     state_d = ss_evt ? STOPPED : lap_evt ? RUN : LAP;
      STOPPED: state_d = ss_evt ? RUN : clr_evt ? CLEARED : STOPPED;
    endcase
  end
  assign active = (state_q == RUN) || (state_q == LAP);
  assign tick   = active && (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d  = (state_d == CLEARED) ? '0 : !active ? pre_q : tick ? '0 : pre_q + 1'b1;
  // tick and clear decode the current state; the level outputs decode the next state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= CLEARED;
      pre_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      hold_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_en_q  <= tick;
      cnt_clr_q <= (state_q == STOPPED) && (state_d == CLEARED);
      hold_q    <= state_d == LAP;
      running_q <= (state_d == RUN) || (state_d == LAP);
    end
  end
  assign cnt_en_o    = cnt_en_q;
  assign cnt_clr_o   = cnt_clr_q;
  assign disp_hold_o = hold_q;
  assign running_o   = running_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenario tests for stopwatch_ctrl with TICK_DIV=8
module tb_stopwatch_ctrl;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic ss = 1'b0, lp = 1'b0, cl = 1'b0;
  logic cnt_en_o, cnt_clr_o, disp_hold_o, running_o;
  logic [1:0] state_o;
  logic [5:0] outs;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  stopwatch_ctrl #(.TICK_DIV(8), .PRE_W(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .strtstop_i(ss), .lap_i(lp), .clr_i(cl),
    .cnt_en_o(cnt_en_o), .cnt_clr_o(cnt_clr_o), .disp_hold_o(disp_hold_o),
    .running_o(running_o), .state_o(state_o)
  );
  // {state, running, hold, cnt_en, cnt_clr}
  assign outs = {state_o, running_o, disp_hold_o, cnt_en_o, cnt_clr_o};
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic press(input logic s, input logic c, input logic l);
    ss = s; cl = c; lp = l;
    step(2);
    ss = 1'b0; cl = 1'b0; lp = 1'b0;
    step(1);
  endtask
  task automatic test_reset;
    step(2);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL reset_hold: outs=%b expected 000000", outs); end
    #2 rst_n_i = 1'b1;
    step(3);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL post_release: outs=%b expected 000000", outs); end
    checks++; if (dut.pre_q !== 3'd0) begin errors++; $display("FAIL reset_pre: pre=%0d expected 0", dut.pre_q); end
  endtask
  task automatic test_start;
    logic [5:0] exp;
    ss = 1'b1;
    step(2);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL start_latency: outs=%b expected 000000", outs); end
    ss = 1'b0;
    step(1);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL start_run: outs=%b expected 011000", outs); end
    for (int p = 0; p < 2; p++)
      for (int i = 1; i <= 8; i++) begin
        step(1);
        exp = (i == 8) ? 6'b011010 : 6'b011000;
        checks++; if (outs !== exp) begin errors++; $display("FAIL tick_period p%0d c%0d: outs=%b expected %b", p, i, outs, exp); end
      end
  endtask
  task automatic test_pause;
    logic [5:0] exp;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      exp = (i == 8) ? 6'b011010 : 6'b011000;
      checks++; if (outs !== exp) begin errors++; $display("FAIL third_tick c%0d: outs=%b expected %b", i, outs, exp); end
    end
    step(2);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b100000) begin errors++; $display("FAIL pause_stop: outs=%b expected 100000", outs); end
    checks++; if (dut.pre_q !== 3'd5) begin errors++; $display("FAIL pause_pre: pre=%0d expected 5", dut.pre_q); end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++; if (outs !== 6'b100000) begin errors++; $display("FAIL pause_idle c%0d: outs=%b expected 100000", i, outs); end
    end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL resume: outs=%b expected 011000", outs); end
    for (int i = 1; i <= 3; i++) begin
      step(1);
      exp = (i == 3) ? 6'b011010 : 6'b011000;
      checks++; if (outs !== exp) begin errors++; $display("FAIL resume_tick c%0d: outs=%b expected %b", i, outs, exp); end
    end
  endtask
  task automatic test_lap;
    int n;
    n = 0;
    press(1'b0, 1'b0, 1'b1);
    checks++; if (outs !== 6'b111100) begin errors++; $display("FAIL lap_enter: outs=%b expected 111100", outs); end
    for (int i = 1; i <= 24; i++) begin
      if (i == 5) cl = 1'b1;
      if (i == 7) cl = 1'b0;
      step(1);
      if (cnt_en_o) n++;
      checks++; if (outs[5:2] !== 4'b1111) begin errors++; $display("FAIL lap_hold c%0d: outs=%b expected 1111xx", i, outs); end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL lap_ticks: count=%0d expected 3", n); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL lap_exit: outs=%b expected 011000", outs); end
  endtask
  task automatic test_clear;
    press(1'b0, 1'b1, 1'b0);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL clr_in_run: outs=%b expected 011000", outs); end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b100000) begin errors++; $display("FAIL stop_for_clr: outs=%b expected 100000", outs); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (outs !== 6'b000001) begin errors++; $display("FAIL clr_pulse: outs=%b expected 000001", outs); end
    checks++; if (dut.pre_q !== 3'd0) begin errors++; $display("FAIL clr_pre: pre=%0d expected 0", dut.pre_q); end
    step(1);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL clr_single: outs=%b expected 000000", outs); end
  endtask
  task automatic test_simultaneous;
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL sim_start: outs=%b expected 011000", outs); end
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b100000) begin errors++; $display("FAIL sim_stop: outs=%b expected 100000", outs); end
    press(1'b1, 1'b1, 1'b0);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL ss_clr_run: outs=%b expected 011000", outs); end
    step(1);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL ss_clr_noclr: outs=%b expected 011000", outs); end
    step(1);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b100010) begin errors++; $display("FAIL terminal_stop: outs=%b expected 100010", outs); end
    step(1);
    checks++; if (outs !== 6'b100000) begin errors++; $display("FAIL terminal_after: outs=%b expected 100000", outs); end
  endtask
  task automatic test_async_reset;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++; if (outs !== 6'b111100) begin errors++; $display("FAIL rst_lap_setup: outs=%b expected 111100", outs); end
    #3 rst_n_i = 1'b0;
    #1;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL async_reset: outs=%b expected 000000", outs); end
    checks++; if (dut.pre_q !== 3'd0) begin errors++; $display("FAIL async_pre: pre=%0d expected 0", dut.pre_q); end
    ss = 1'b1;
    step(2);
    #2 rst_n_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL held_across_release c%0d: outs=%b expected 000000", i, outs); end
    end
    ss = 1'b0;
    step(3);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (outs !== 6'b011000) begin errors++; $display("FAIL after_reset_start: outs=%b expected 011000", outs); end
  endtask
  initial begin
    test_reset;
    test_start;
    test_pause;
    test_lap;
    test_clear;
    test_simultaneous;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
